// File: rtl/div_by_n_ctrl.sv
// div_by_n_ctrl: run-time configurable divide-by-N clock-enable generator.
// The divide counter and the active divisor live here. New divisors arrive on a
// valid/ready port and are only swapped in at a period boundary, so a period is
// never cut short or stretched by a reconfiguration.
module div_by_n_ctrl #(
   parameter int W       = 8,
   parameter int DEF_DIV = 5,
   parameter int MIN_DIV = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_div,
   output logic         cfg_ready,
   output logic         cfg_err,
   output logic         out,
   output logic         period_tick,
   output logic         busy,
   output logic [W-1:0] cur_div
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam logic [W-1:0] DEF_DIV_C = W'(DEF_DIV);
   localparam logic [W-1:0] MIN_DIV_C = W'(MIN_DIV);
   localparam logic [W-1:0] ONE_C     = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] ZERO_C    = {W{1'b0}};
   localparam logic [W:0]   ONE_X_C   = {{W{1'b0}}, 1'b1};

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]   cur_div_q, cur_div_d;
   logic [W-1:0]   pend_div_q, pend_div_d;
   logic           out_q, out_d;
   logic           cfg_err_q, cfg_err_d;

   logic [W:0]     half_s;
   logic [W:0]     cnt_inc_s;
   logic           last_s;
   logic           accept_s;
   logic           bad_s;
   logic           good_s;

   // Derived period decode and handshake qualification from the current registers.
   always_comb begin
      half_s    = ({1'b0, cur_div_q} + ONE_X_C) >> 1;
      cnt_inc_s = {1'b0, cnt_q} + ONE_X_C;
      last_s    = (cnt_q == (cur_div_q - ONE_C));
      accept_s  = cfg_valid & (state_q != ST_PEND);
      bad_s     = accept_s & (cfg_div < MIN_DIV_C);
      good_s    = accept_s & ~bad_s;
   end

   // Next-state logic: counter, output phase, divisor swap and handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      out_d      = out_q;
      cfg_err_d  = bad_s;
      case (state_q)
         ST_IDLE: begin
            cnt_d = ZERO_C;
            if (good_s) begin
               cur_div_d = cfg_div;
            end else begin
               cur_div_d = cur_div_q;
            end
            if (enable) begin
               state_d = ST_RUN;
               out_d   = 1'b1;
            end else begin
               state_d = ST_IDLE;
               out_d   = 1'b0;
            end
         end
         ST_RUN, ST_PEND: begin
            if (last_s) begin
               cnt_d = ZERO_C;
               out_d = enable;
               if (state_q == ST_PEND) begin
                  // Parked divisor takes over for the following period.
                  cur_div_d  = pend_div_q;
                  pend_div_d = ZERO_C;
                  state_d    = enable ? ST_RUN : ST_IDLE;
               end else if (good_s && enable) begin
                  // Accepted on the boundary itself: park it for one more period.
                  pend_div_d = cfg_div;
                  state_d    = ST_PEND;
               end else if (good_s) begin
                  // Stopping anyway, so there is no period to protect.
                  cur_div_d = cfg_div;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = enable ? ST_RUN : ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + ONE_C;
               out_d = (cnt_inc_s < half_s);
               if (good_s) begin
                  pend_div_d = cfg_div;
                  state_d    = ST_PEND;
               end else begin
                  state_d = state_q;
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            cnt_d      = ZERO_C;
            out_d      = 1'b0;
            pend_div_d = ZERO_C;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= ZERO_C;
         cur_div_q  <= DEF_DIV_C;
         pend_div_q <= ZERO_C;
         out_q      <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         out_q      <= out_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign out         = out_q;
   assign cfg_err     = cfg_err_q;
   assign cur_div     = cur_div_q;
   assign busy        = (state_q != ST_IDLE);
   assign cfg_ready   = (state_q != ST_PEND);
   assign period_tick = (state_q != ST_IDLE) & last_s;

endmodule

// File: tb/tb_div_by_n_ctrl.sv
// tb_div_by_n_ctrl: directed bench for div_by_n_ctrl with a period-level reference model.
module tb_div_by_n_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       cfg_err;
   logic       out;
   logic       period_tick;
   logic       busy;
   logic [7:0] cur_div;

   int nvec = 0;
   int nmis = 0;
   bit chk_en = 1'b0;

   // reference model: running flag, position in period, divisor, parked divisor (-1 = none)
   bit m_run;
   int m_pos;
   int m_n;
   int m_pend;
   bit m_err;
   bit m_acc;
   bit m_good;
   int m_nd;

   div_by_n_ctrl #(.W(8), .DEF_DIV(5), .MIN_DIV(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .cfg_valid   (cfg_valid),
      .cfg_div     (cfg_div),
      .cfg_ready   (cfg_ready),
      .cfg_err     (cfg_err),
      .out         (out),
      .period_tick (period_tick),
      .busy        (busy),
      .cur_div     (cur_div)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: one step per rising edge, following the behavioural rules.
   always @(posedge clk) begin
      if (!rst) begin
         m_run  = 1'b0;
         m_pos  = 0;
         m_n    = 5;
         m_pend = -1;
         m_err  = 1'b0;
      end else begin
         m_nd   = int'(cfg_div);
         m_acc  = cfg_valid && (m_pend < 0);
         m_err  = m_acc && (m_nd < 2);
         m_good = m_acc && (m_nd >= 2);
         if (!m_run) begin
            if (m_good) m_n = m_nd;
            if (enable) begin
               m_run = 1'b1;
               m_pos = 0;
            end
         end else if (m_pos == m_n - 1) begin
            if (m_pend >= 0) begin
               m_n    = m_pend;
               m_pend = -1;
            end else if (m_good) begin
               if (enable) m_pend = m_nd;
               else        m_n    = m_nd;
            end
            m_pos = 0;
            m_run = enable;
         end else begin
            m_pos = m_pos + 1;
            if (m_good) m_pend = m_nd;
         end
      end
   end

   // Compare process: every falling edge once reset has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out",         32'(out),         32'(m_run && (m_pos < (m_n + 1) / 2)));
         chk("period_tick", 32'(period_tick), 32'(m_run && (m_pos == m_n - 1)));
         chk("busy",        32'(busy),        32'(m_run));
         chk("cfg_ready",   32'(cfg_ready),   32'(m_pend < 0));
         chk("cfg_err",     32'(cfg_err),     32'(m_err));
         chk("cur_div",     32'(cur_div),     32'(m_n));
      end
   end

   task automatic collect(input int n, output logic [31:0] ov, output logic [31:0] tv);
      ov = 32'd0;
      tv = 32'd0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ov = {ov[30:0], out};
         tv = {tv[30:0], period_tick};
      end
   endtask

   task automatic wait_at(input int n, input int p);
      int k;
      k = 0;
      while (!(m_run && m_n == n && m_pos == p) && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("wait_at_timeout", 32'(k >= 60), 32'd0);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (m_run && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("wait_idle_timeout", 32'(k >= 60), 32'd0);
   endtask

   logic [31:0] ov;
   logic [31:0] tv;

   initial begin
      rst       = 1'b0;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_out",   32'(out),       32'd0);
      chk("rst_cur",   32'(cur_div),   32'd5);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk_en = 1'b1;

      // 1: default N=5
      rst    = 1'b1;
      enable = 1'b1;
      collect(10, ov, tv);
      chk("n5_out",  ov, 32'b1110011100);
      chk("n5_tick", tv, 32'b0000100001);

      // 2: offer 4 at cnt=1
      wait_at(5, 1);
      cfg_valid = 1'b1;
      cfg_div   = 8'd4;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("pend_ready", 32'(cfg_ready), 32'd0);
      collect(10, ov, tv);
      chk("n5to4_out",  ov, 32'b0011001100);
      chk("n5to4_tick", tv, 32'b0100010001);
      chk("n4_cur",     32'(cur_div), 32'd4);

      // 3: illegal divisor
      cfg_valid = 1'b1;
      cfg_div   = 8'd1;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("err_pulse", 32'(cfg_err), 32'd1);
      @(negedge clk);
      chk("err_clear", 32'(cfg_err), 32'd0);
      chk("err_cur",   32'(cur_div), 32'd4);

      // back-to-back offers: only the first is taken
      cfg_valid = 1'b1;
      cfg_div   = 8'd3;
      @(negedge clk);
      cfg_div = 8'd7;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("b2b_ready", 32'(cfg_ready), 32'd0);
      wait_at(3, 0);
      chk("b2b_cur", 32'(cur_div), 32'd3);

      // offer coinciding with Last: parked for one more period
      wait_at(3, 2);
      cfg_valid = 1'b1;
      cfg_div   = 8'd6;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("last_cur_old", 32'(cur_div),   32'd3);
      chk("last_ready",   32'(cfg_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("last_cur_new", 32'(cur_div),   32'd6);

      // 4: back to N=5, then drop enable at cnt=1
      wait_at(6, 0);
      cfg_valid = 1'b1;
      cfg_div   = 8'd5;
      @(negedge clk);
      cfg_valid = 1'b0;
      wait_at(5, 1);
      enable = 1'b0;
      collect(4, ov, tv);
      chk("drop_out",  ov, 32'b1000);
      chk("drop_busy", 32'(busy), 32'd0);

      // 5: reset while a divisor is parked
      enable = 1'b1;
      wait_at(5, 1);
      cfg_valid = 1'b1;
      cfg_div   = 8'd3;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("r_pend_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("r_out",   32'(out),       32'd0);
      chk("r_cur",   32'(cur_div),   32'd5);
      chk("r_ready", 32'(cfg_ready), 32'd1);
      chk("r_busy",  32'(busy),      32'd0);
      collect(10, ov, tv);
      chk("r_n5_out", ov, 32'b1110011100);

      // 6: N=2 configured in IDLE
      enable = 1'b0;
      wait_idle();
      cfg_valid = 1'b1;
      cfg_div   = 8'd0;
      @(negedge clk);
      chk("idle_err", 32'(cfg_err), 32'd1);
      cfg_div = 8'd2;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("idle_cur", 32'(cur_div), 32'd2);
      enable = 1'b1;
      collect(6, ov, tv);
      chk("n2_out",  ov, 32'b101010);
      chk("n2_tick", tv, 32'b010101);
      enable = 1'b0;
      repeat (4) @(negedge clk);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
